// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory access unit.
// Split support in dm_access_unit is selected with DM_SPLIT_UNALIGNED_EN.
package dm_pkg;

    typedef enum logic [1:0] {
        W_BYTE  = 2'd0,
        W_HALF  = 2'd1,
        W_WORD  = 2'd2,
        W_DWORD = 2'd3
    } width_e;

    typedef enum logic [1:0] {
        P_NONE  = 2'd0,
        P_LEFT  = 2'd1,
        P_RIGHT = 2'd2
    } part_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ISSUE0 = 3'd1;
    localparam state_t ST_WAIT0  = 3'd2;
    localparam state_t ST_ISSUE1 = 3'd3;
    localparam state_t ST_WAIT1  = 3'd4;
    localparam state_t ST_RESP   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    function automatic logic [7:0] byte_mask(input int n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_lane_shifter.sv
// Combinational byte-lane steering: per-beat enables/store data and
// load merge with zero/sign extension.
module dm_lane_shifter
    import dm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic [1:0]                  width,
    input  logic [1:0]                  part,
    input  logic                        sign,
    input  logic                        beat,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           orig,
    input  logic [DATA_W-1:0]           rdata0,
    input  logic [DATA_W-1:0]           rdata1,
    output logic [DATA_W/8-1:0]         be,
    output logic [DATA_W-1:0]           wdata_sh,
    output logic [DATA_W-1:0]           load_data
);

    localparam int B = DATA_W / 8;

    int                o;
    int                n;
    logic [7:0]        nmask;
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] data;
    logic              msb;

    always_comb begin
        o         = int'(off);
        n         = 1 << width;
        nmask     = byte_mask(n);
        ones      = '1;
        be        = '0;
        wdata_sh  = '0;
        load_data = '0;
        data      = '0;
        msb       = 1'b0;
        if (part == P_LEFT) begin
            for (int i = 0; i < B; i++) be[i] = (i <= o);
            wdata_sh  = wdata >> ((B - 1 - o) * 8);
            load_data = (rdata0 << ((B - 1 - o) * 8)) | (orig & ~(ones << ((B - 1 - o) * 8)));
        end else if (part == P_RIGHT) begin
            for (int i = 0; i < B; i++) be[i] = (i >= o);
            wdata_sh  = wdata << (o * 8);
            load_data = (rdata0 >> (o * 8)) | (orig & ~(ones >> (o * 8)));
        end else begin
            if (beat) begin
                for (int i = 0; i < B; i++) be[i] = (i < o + n - B);
                wdata_sh = wdata >> ((B - o) * 8);
            end else begin
                for (int i = 0; i < B; i++) be[i] = (i >= o) && (i < o + n);
                wdata_sh = wdata << (o * 8);
            end
            // Beat 1 bytes land above beat 0's upper lanes; for single-beat
            // accesses they sit beyond n bytes and are dropped by the mask.
            data = (rdata0 >> (o * 8)) | (rdata1 << ((B - o) * 8));
            for (int i = 0; i < B; i++) begin
                if (i == n - 1) msb = data[8*i+7];
            end
            for (int i = 0; i < B; i++) begin
                if (nmask[i]) load_data[8*i +: 8] = data[8*i +: 8];
                else          load_data[8*i +: 8] = {8{sign & msb}};
            end
        end
    end

endmodule

// File: rtl/dm_access_unit.sv
// Sequential load/store unit driving an addr_ok/data_ok bus, one beat at a time.
// Define DM_SPLIT_UNALIGNED_EN to split beat-crossing misaligned accesses.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_width,
    input  logic                req_sign,
    input  logic [1:0]          req_part,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W-1:0]   req_orig,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_addr_err
);

    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);

    state_t             state;
    state_t             state_nxt;
    logic               r_write;
    logic               r_sign;
    logic [1:0]         r_width;
    logic [1:0]         r_part;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_orig;
    logic [DATA_W-1:0]  beat0;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  load_data;
    logic [ADDR_W-1:0]  base;
    logic               beat_sel;
    logic               req_illegal;

`ifdef DM_SPLIT_UNALIGNED_EN
    logic [DATA_W-1:0]  beat1;
    logic               crosses;

    assign crosses  = (r_part == P_NONE) && (int'(r_addr[OFF_W-1:0]) + (1 << r_width) > B);
    assign beat_sel = (state == ST_ISSUE1);
    assign rdata1   = beat1;
`else
    int                 req_off;
    int                 req_n;

    assign beat_sel = 1'b0;
    assign rdata1   = '0;
`endif

    // Legality is decided at accept so an illegal request answers one cycle later.
    always_comb begin
        req_illegal = 1'b0;
`ifndef DM_SPLIT_UNALIGNED_EN
        req_off = int'(req_addr[OFF_W-1:0]);
        req_n   = 1 << req_width;
`endif
        if (req_part == 2'd3) begin
            req_illegal = 1'b1;
        end else if (req_part == P_NONE) begin
            if (req_width == W_DWORD && DATA_W == 32) req_illegal = 1'b1;
`ifndef DM_SPLIT_UNALIGNED_EN
            if ((req_off & (req_n - 1)) != 0) req_illegal = 1'b1;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = req_illegal ? ST_ERR : ST_ISSUE0;
            ST_ISSUE0: if (bus_addr_ok) state_nxt = ST_WAIT0;
`ifdef DM_SPLIT_UNALIGNED_EN
            ST_WAIT0:  if (bus_data_ok) state_nxt = crosses ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (bus_addr_ok) state_nxt = ST_WAIT1;
            ST_WAIT1:  if (bus_data_ok) state_nxt = ST_RESP;
`else
            ST_WAIT0:  if (bus_data_ok) state_nxt = ST_RESP;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            beat0 <= '0;
`ifdef DM_SPLIT_UNALIGNED_EN
            beat1 <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT0 && bus_data_ok) beat0 <= bus_rdata;
`ifdef DM_SPLIT_UNALIGNED_EN
            if (state == ST_WAIT1 && bus_data_ok) beat1 <= bus_rdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            r_write <= req_write;
            r_width <= req_width;
            r_sign  <= req_sign;
            r_part  <= req_part;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_orig  <= req_orig;
        end
    end

    dm_lane_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .off       (r_addr[OFF_W-1:0]),
        .width     (r_width),
        .part      (r_part),
        .sign      (r_sign),
        .beat      (beat_sel),
        .wdata     (r_wdata),
        .orig      (r_orig),
        .rdata0    (beat0),
        .rdata1    (rdata1),
        .be        (bus_be),
        .wdata_sh  (bus_wdata),
        .load_data (load_data)
    );

    assign base          = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign req_ready     = (state == ST_IDLE);
    assign bus_req       = (state == ST_ISSUE0) || beat_sel;
    assign bus_wr        = r_write;
    assign bus_addr      = beat_sel ? base + ADDR_W'(B) : base;
    assign resp_valid    = (state == ST_RESP) || (state == ST_ERR);
    assign resp_addr_err = (state == ST_ERR);
    assign resp_data     = (state == ST_RESP && !r_write) ? load_data : '0;

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit (DATA_W=32); split cases follow
// DM_SPLIT_UNALIGNED_EN.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_sign;
    logic [1:0]  req_part;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_orig;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_addr_err;

    dm_access_unit #(
        .DATA_W (32),
        .ADDR_W (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_width     (req_width),
        .req_sign      (req_sign),
        .req_part      (req_part),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_orig      (req_orig),
        .bus_req       (bus_req),
        .bus_wr        (bus_wr),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_addr_ok   (bus_addr_ok),
        .bus_data_ok   (bus_data_ok),
        .bus_rdata     (bus_rdata),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_addr_err (resp_addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  w;
        logic        sg;
        logic [1:0]  p;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] og;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_exp;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc;
    int          resp_cyc;
    int          nbeats;
    logic [31:0] obs_addr[2];
    logic [3:0]  obs_be[2];
    logic [31:0] obs_wdata[2];
    logic        obs_wr[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every completion pulse consumes the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: resp_valid with data %h err %b, required no response", resp_data, resp_addr_err);
            end else begin
                mon_exp = sb.pop_front();
                checks++;
                if (resp_data !== mon_exp.data) begin
                    errors++;
                    $display("FAIL sb_data: got %h, expected %h", resp_data, mon_exp.data);
                end
                checks++;
                if (resp_addr_err !== mon_exp.err) begin
                    errors++;
                    $display("FAIL sb_err: got %b, expected %b", resp_addr_err, mon_exp.err);
                end
            end
        end
    end

    // Drives one request and plays the bus with minimum latency.
    task automatic run_req(input logic wr, input logic [1:0] w, input logic sg, input logic [1:0] p,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] og,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        logic pend;
        logic done;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_width = w; req_sign = sg; req_part = p;
        req_addr = a; req_wdata = wd; req_orig = og;
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc = cyc; nbeats = 0; pend = 1'b0; done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
            if (resp_valid) begin
                resp_cyc = cyc; done = 1'b1;
            end else if (pend) begin
                bus_data_ok = 1'b1;
                bus_rdata = (nbeats == 1) ? rd0 : rd1;
                pend = 1'b0;
            end else if (bus_req) begin
                if (nbeats < 2) begin
                    obs_addr[nbeats] = bus_addr; obs_be[nbeats] = bus_be;
                    obs_wdata[nbeats] = bus_wdata; obs_wr[nbeats] = bus_wr;
                end
                nbeats++;
                bus_addr_ok = 1'b1;
                pend = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        if (!done) begin
            checks++; errors++;
            resp_cyc = cyc;
            $display("FAIL run_timeout: no resp_valid within 30 cycles for addr %h", a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, expected 1", req_ready); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b, expected 0", bus_req); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b, expected 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h, expected 0", resp_data); end
        checks++; if (resp_addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b, expected 0", resp_addr_err); end
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        vec_t v[12];
        v[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 32'h1003, 32'h123456AB, 32'h0, 32'h0, 32'h1000, 4'b1000, 32'hAB000000, 32'h0};
        v[1]  = '{1'b0, 2'd1, 1'b1, 2'd0, 32'h2002, 32'h0, 32'h0, 32'h80011234, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001};
        v[2]  = '{1'b0, 2'd1, 1'b0, 2'd0, 32'h2002, 32'h0, 32'h0, 32'h80011234, 32'h2000, 4'b1100, 32'h0, 32'h00008001};
        v[3]  = '{1'b0, 2'd0, 1'b1, 2'd0, 32'h2003, 32'h0, 32'h0, 32'h80011234, 32'h2000, 4'b1000, 32'h0, 32'hFFFFFF80};
        v[4]  = '{1'b0, 2'd0, 1'b1, 2'd0, 32'h2001, 32'h0, 32'h0, 32'h80011234, 32'h2000, 4'b0010, 32'h0, 32'h00000012};
        v[5]  = '{1'b0, 2'd0, 1'b0, 2'd1, 32'h4001, 32'h0, 32'h11223344, 32'hAABBCCDD, 32'h4000, 4'b0011, 32'h0, 32'hCCDD3344};
        v[6]  = '{1'b0, 2'd0, 1'b0, 2'd2, 32'h4001, 32'h0, 32'h11223344, 32'hAABBCCDD, 32'h4000, 4'b1110, 32'h0, 32'h11AABBCC};
        v[7]  = '{1'b1, 2'd2, 1'b0, 2'd1, 32'h4002, 32'hAABBCCDD, 32'h0, 32'h0, 32'h4000, 4'b0111, 32'h00AABBCC, 32'h0};
        v[8]  = '{1'b1, 2'd2, 1'b0, 2'd2, 32'h4002, 32'hAABBCCDD, 32'h0, 32'h0, 32'h4000, 4'b1100, 32'hCCDD0000, 32'h0};
        v[9]  = '{1'b1, 2'd2, 1'b0, 2'd0, 32'h3000, 32'hDEADBEEF, 32'h0, 32'h0, 32'h3000, 4'b1111, 32'hDEADBEEF, 32'h0};
        v[10] = '{1'b1, 2'd1, 1'b0, 2'd0, 32'h3002, 32'h1234BEEF, 32'h0, 32'h0, 32'h3000, 4'b1100, 32'hBEEF0000, 32'h0};
        v[11] = '{1'b0, 2'd2, 1'b1, 2'd0, 32'h3004, 32'h0, 32'h0, 32'h89ABCDEF, 32'h3004, 4'b1111, 32'h0, 32'h89ABCDEF};
        for (int i = 0; i < 12; i++) begin
            sb.push_back('{v[i].e_data, 1'b0});
            run_req(v[i].wr, v[i].w, v[i].sg, v[i].p, v[i].a, v[i].wd, v[i].og, v[i].rd, 32'h0);
            checks++; if (nbeats !== 1) begin errors++; $display("FAIL lane_beats[%0d]: got %0d, expected 1", i, nbeats); end
            checks++; if (obs_addr[0] !== v[i].e_addr) begin errors++; $display("FAIL lane_addr[%0d]: got %h, expected %h", i, obs_addr[0], v[i].e_addr); end
            checks++; if (obs_be[0] !== v[i].e_be) begin errors++; $display("FAIL lane_be[%0d]: got %b, expected %b", i, obs_be[0], v[i].e_be); end
            checks++; if (obs_wr[0] !== v[i].wr) begin errors++; $display("FAIL lane_wr[%0d]: got %b, expected %b", i, obs_wr[0], v[i].wr); end
            if (v[i].wr) begin
                checks++; if (obs_wdata[0] !== v[i].e_wdata) begin errors++; $display("FAIL lane_wdata[%0d]: got %h, expected %h", i, obs_wdata[0], v[i].e_wdata); end
            end
            checks++; if (resp_cyc - acc_cyc + 1 !== 3) begin errors++; $display("FAIL lane_latency[%0d]: got %0d, expected 3", i, resp_cyc - acc_cyc + 1); end
        end
    endtask

    task automatic test_misaligned();
`ifdef DM_SPLIT_UNALIGNED_EN
        sb.push_back('{32'h44332211, 1'b0});
        run_req(1'b0, 2'd2, 1'b0, 2'd0, 32'h0006, 32'h0, 32'h0, 32'h22110000, 32'h00004433);
        checks++; if (nbeats !== 2) begin errors++; $display("FAIL split_ld_beats: got %0d, expected 2", nbeats); end
        checks++; if (obs_addr[0] !== 32'h4 || obs_addr[1] !== 32'h8) begin errors++; $display("FAIL split_ld_addr: got %h/%h, expected 00000004/00000008", obs_addr[0], obs_addr[1]); end
        checks++; if (obs_be[0] !== 4'b1100 || obs_be[1] !== 4'b0011) begin errors++; $display("FAIL split_ld_be: got %b/%b, expected 1100/0011", obs_be[0], obs_be[1]); end
        checks++; if (resp_cyc - acc_cyc + 1 !== 5) begin errors++; $display("FAIL split_ld_latency: got %0d, expected 5", resp_cyc - acc_cyc + 1); end
        sb.push_back('{32'h0, 1'b0});
        run_req(1'b1, 2'd2, 1'b0, 2'd0, 32'h0006, 32'h44332211, 32'h0, 32'h0, 32'h0);
        checks++; if (obs_wdata[0] !== 32'h22110000 || obs_wdata[1] !== 32'h00004433) begin errors++; $display("FAIL split_st_wdata: got %h/%h, expected 22110000/00004433", obs_wdata[0], obs_wdata[1]); end
        checks++; if (obs_be[0] !== 4'b1100 || obs_be[1] !== 4'b0011) begin errors++; $display("FAIL split_st_be: got %b/%b, expected 1100/0011", obs_be[0], obs_be[1]); end
        sb.push_back('{32'h0000BBCC, 1'b0});
        run_req(1'b0, 2'd1, 1'b0, 2'd0, 32'h0001, 32'h0, 32'h0, 32'hAABBCCDD, 32'h0);
        checks++; if (nbeats !== 1) begin errors++; $display("FAIL inbeat_beats: got %0d, expected 1", nbeats); end
        checks++; if (obs_be[0] !== 4'b0110) begin errors++; $display("FAIL inbeat_be: got %b, expected 0110", obs_be[0]); end
`else
        sb.push_back('{32'h0, 1'b1});
        run_req(1'b1, 2'd2, 1'b0, 2'd0, 32'h0006, 32'h44332211, 32'h0, 32'h0, 32'h0);
        checks++; if (nbeats !== 0) begin errors++; $display("FAIL mis_st_beats: got %0d, expected 0", nbeats); end
        checks++; if (resp_cyc - acc_cyc + 1 !== 1) begin errors++; $display("FAIL mis_st_latency: got %0d, expected 1", resp_cyc - acc_cyc + 1); end
        sb.push_back('{32'h0, 1'b1});
        run_req(1'b0, 2'd1, 1'b1, 2'd0, 32'h0001, 32'h0, 32'h0, 32'hAABBCCDD, 32'h0);
        checks++; if (nbeats !== 0) begin errors++; $display("FAIL mis_ld_beats: got %0d, expected 0", nbeats); end
`endif
        sb.push_back('{32'h0, 1'b1});
        run_req(1'b0, 2'd3, 1'b0, 2'd0, 32'h0000, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0);
        checks++; if (nbeats !== 0) begin errors++; $display("FAIL dword_beats: got %0d, expected 0", nbeats); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'h0000005A, 1'b0});
        run_req(1'b0, 2'd0, 1'b1, 2'd0, 32'h5000, 32'h0, 32'h0, 32'h0000005A, 32'h0);
        sb.push_back('{32'hFFFFA5C3, 1'b0});
        run_req(1'b0, 2'd1, 1'b1, 2'd0, 32'h5006, 32'h0, 32'h0, 32'hA5C30000, 32'h0);
        checks++; if (obs_addr[0] !== 32'h5004) begin errors++; $display("FAIL b2b_addr: got %h, expected 00005004", obs_addr[0]); end
        checks++; if (resp_cyc - acc_cyc + 1 !== 3) begin errors++; $display("FAIL b2b_latency: got %0d, expected 3", resp_cyc - acc_cyc + 1); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_width = 2'd2; req_sign = 1'b0; req_part = 2'd0;
        req_addr = 32'h2000; req_wdata = 32'h0; req_orig = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got bus_req %b, expected 1", bus_req); end
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got req_ready %b, expected 0", req_ready); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_bus_req: got %b, expected 0", bus_req); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, expected 1", req_ready); end
        bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_ok[%0d]: got resp_valid %b, expected 0", i, resp_valid); end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_width = 2'd0; req_sign = 1'b0;
        req_part = 2'd0; req_addr = 32'h0; req_wdata = 32'h0; req_orig = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_single_beat();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
